pipe_hazard_ctrl: RTL and testbench

- Scoreboard-based hazard controller for the 5-stage pipeline: IF, ID, RR, EX, WB.
- Tracks the destination register of every instruction in flight beyond ID.
- Compares it against the sources of the instruction in ID, and produces stall, bubble and flush controls for the IF/ID and ID/RR pipeline registers.
- Sits beside the per-stage control blocks; WB control still owns RFWrite/RegIn.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_hazard_ctrl_if.sv | 24 ++
 rtl/instr_decode_regs.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 96 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, register index width,
// decode record and scoreboard entry.
package pipe_pkg;

  localparam int RIDX_W = 2;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [2:0] ORI_LO   = 3'b111;
  localparam logic [2:0] SHIFT_LO = 3'b011;

  typedef struct packed {
    logic              is_writer;
    logic              is_load;
    logic [RIDX_W-1:0] dest;
    logic [RIDX_W-1:0] src_a;
    logic [RIDX_W-1:0] src_b;
    logic              use_a;
    logic              use_b;
  } dec_t;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] dest;
    logic              is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID stage / pipeline register control and the hazard controller.
interface pipe_hazard_ctrl_if;
  // No valid/ready handshake: IDValid only qualifies IDInstr in the same cycle; the
  // controller answers combinationally and the IF/ID register holds while Stall=1.
  logic [7:0]  IDInstr;
  logic        IDValid;
  logic        BrTaken;
  logic        Stall;
  logic        Bubble;
  logic        Flush;
  logic [1:0]  FwdSelA;
  logic [1:0]  FwdSelB;
  logic [15:0] StallCnt;

  modport master (
    output IDInstr, IDValid, BrTaken,
    input  Stall, Bubble, Flush, FwdSelA, FwdSelB, StallCnt
  );

  modport slave (
    input  IDInstr, IDValid, BrTaken,
    output Stall, Bubble, Flush, FwdSelA, FwdSelB, StallCnt
  );
endinterface

// File: rtl/instr_decode_regs.sv
// Combinational register-usage decode of one 8-bit instruction: writer/load flags,
// destination and source registers.
module instr_decode_regs
  import pipe_pkg::*;
(
  input  logic [7:0] instr,
  output dec_t       dec
);

  logic [3:0] op;
  logic       is_ori;
  logic       is_shift;
  logic       no_src;

  assign op = instr[3:0];

  always_comb begin
    is_ori   = (op[2:0] == ORI_LO);
    is_shift = (op[2:0] == SHIFT_LO);
    no_src   = (op == OP_STOP) || (op == OP_NOP) || (op == OP_BZ) ||
               (op == OP_BNZ) || (op == OP_BPZ);

    dec           = '0;
    dec.is_writer = !no_src && (op != OP_STORE);
    dec.is_load   = (op == OP_LOAD);
    // ori carries an immediate in [7:3], so it implicitly reads and writes R1
    dec.dest      = is_ori ? RIDX_W'(1) : instr[7:6];
    dec.src_a     = is_ori ? RIDX_W'(1) : instr[7:6];
    dec.src_b     = instr[5:4];
    dec.use_a     = !no_src;
    dec.use_b     = !no_src && !is_ori && !is_shift;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard controller for the IF/ID/RR/EX/WB pipeline; entry 0 is RR.
// Optional operand forwarding is enabled by defining PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave ctl
);

  dec_t             id_dec;
  sb_entry_t        sb [DEPTH];
  logic [DEPTH-2:0] match_a;
  logic [DEPTH-2:0] match_b;
  logic             hazard;
  logic             stall;
  logic             flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [15:0]      stall_cnt;

  instr_decode_regs u_dec (
    .instr (ctl.IDInstr),
    .dec   (id_dec)
  );

  // The WB entry is never compared: the RF writes in the first half and reads in the second.
  always_comb begin
    for (int k = 0; k < DEPTH-1; k++) begin
      match_a[k] = !reset && ctl.IDValid && sb[k].valid && id_dec.use_a &&
                   (sb[k].dest == id_dec.src_a);
      match_b[k] = !reset && ctl.IDValid && sb[k].valid && id_dec.use_b &&
                   (sb[k].dest == id_dec.src_b);
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  always_comb begin
    hazard = (match_a[0] || match_b[0]) && sb[0].is_load;
  end
`else
  always_comb begin
    hazard = (|match_a) || (|match_b);
  end
`endif

  assign flush = !reset && ctl.BrTaken;
  assign stall = hazard && !ctl.BrTaken;

`ifdef PIPE_HAZARD_FWD_EN
  // Youngest producer wins: a match in RR will be in EX when the consumer reaches RR.
  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (match_a[DEPTH-2]) fwd_a = 2'd2;
    if (match_a[0])       fwd_a = 2'd1;
    if (match_b[DEPTH-2]) fwd_b = 2'd2;
    if (match_b[0])       fwd_b = 2'd1;
    if (stall || flush) begin
      fwd_a = 2'd0;
      fwd_b = 2'd0;
    end
  end
`else
  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
      stall_cnt <= '0;
    end else begin
      sb[0].valid   <= ctl.IDValid && !stall && !ctl.BrTaken && id_dec.is_writer;
      sb[0].dest    <= id_dec.dest;
      sb[0].is_load <= id_dec.is_load;
      sb[1]         <= sb[0];
      // The RR occupant is younger than the taken branch and is squashed with it
      if (ctl.BrTaken) sb[1].valid <= 1'b0;
      for (int k = 2; k < DEPTH; k++) sb[k] <= sb[k-1];
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign ctl.Stall    = stall;
  assign ctl.Bubble   = stall;
  assign ctl.Flush    = flush;
  assign ctl.FwdSelA  = fwd_a;
  assign ctl.FwdSelB  = fwd_b;
  assign ctl.StallCnt = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: timeline model of in-flight producers plus literal pins.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clock (clk),
    .reset (rst),
    .ctl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] ADD12  = {2'd1, 2'd2, 4'b0100};
  localparam logic [7:0] SUB31  = {2'd3, 2'd1, 4'b0110};
  localparam logic [7:0] NOP    = {4'b0000, 4'b1010};
  localparam logic [7:0] ADD20  = {2'd2, 2'd0, 4'b0100};
  localparam logic [7:0] ADD32  = {2'd3, 2'd2, 4'b0100};
  localparam logic [7:0] ADD03  = {2'd0, 2'd3, 4'b0100};
  localparam logic [7:0] NAND11 = {2'd1, 2'd1, 4'b1000};
  localparam logic [7:0] ADD22  = {2'd2, 2'd2, 4'b0100};
  localparam logic [7:0] ADD30  = {2'd3, 2'd0, 4'b0100};
  localparam logic [7:0] LOAD20 = {2'd2, 2'd0, 4'b0000};
  localparam logic [7:0] SHF13  = {2'd1, 2'd3, 4'b0011};
  localparam logic [7:0] ORI    = 8'hFF;
  localparam logic [7:0] ST00   = {2'd0, 2'd0, 4'b0010};
  localparam logic [7:0] BZ11   = {2'd1, 2'd1, 4'b0101};
  localparam logic [7:0] ADD11  = {2'd1, 2'd1, 4'b0100};
  localparam logic [7:0] ADD21  = {2'd2, 2'd1, 4'b0100};
  localparam logic [7:0] ADD10  = {2'd1, 2'd0, 4'b0100};

  int checks;
  int failures;
  int cyc;
  bit forcing;

  // Model: every issued writer remembered with the cycle it left ID.
  typedef struct {
    int         t;
    logic [1:0] dest;
    bit         ld;
    bit         live;
  } prod_t;
  prod_t       prods[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_cnt;

  function automatic void chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void ref_dec(input logic [7:0] ins, output bit wr, output bit ld,
                                  output logic [1:0] dst, output bit ua, output logic [1:0] sa,
                                  output bit ub, output logic [1:0] sb);
    wr = 1; ld = 0; dst = ins[7:6]; ua = 1; sa = ins[7:6]; ub = 1; sb = ins[5:4];
    case (ins[3:0])
      4'b0001, 4'b1010, 4'b0101, 4'b1001, 4'b1101: begin wr = 0; ua = 0; ub = 0; end
      4'b0010: wr = 0;
      4'b0011, 4'b1011: ub = 0;
      4'b0111, 4'b1111: begin dst = 2'd1; sa = 2'd1; ub = 0; end
      4'b0000: ld = 1;
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    bit wr, ld, ua, ub, haz, e_stall, lda, ldb;
    logic [1:0] dst, sa, sb;
    int da, db, d;
    logic [1:0] e_fa, e_fb;
    if (rst) begin
      chk("rst_stall", {15'd0, bus.Stall}, 16'd0);
      chk("rst_bubble", {15'd0, bus.Bubble}, 16'd0);
      chk("rst_flush", {15'd0, bus.Flush}, 16'd0);
      chk("rst_fwd", {12'd0, bus.FwdSelA, bus.FwdSelB}, 16'd0);
      chk("rst_cnt", bus.StallCnt, m_cnt);
      prods.delete();
      m_cnt = 16'd0;
    end else if (forcing) begin
      chk("sat_cnt", bus.StallCnt, m_cnt);
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      ref_dec(bus.IDInstr, wr, ld, dst, ua, sa, ub, sb);
      da = 99; db = 99; lda = 0; ldb = 0;
      foreach (prods[i]) begin
        d = cyc - prods[i].t;
        if (prods[i].live && d >= 1 && d <= 2) begin
          if (ua && prods[i].dest == sa && d < da) begin da = d; lda = prods[i].ld; end
          if (ub && prods[i].dest == sb && d < db) begin db = d; ldb = prods[i].ld; end
        end
      end
`ifdef PIPE_HAZARD_FWD_EN
      haz = (da == 1 && lda) || (db == 1 && ldb);
`else
      haz = (da < 99) || (db < 99);
`endif
      e_stall = bus.IDValid && haz && !bus.BrTaken;
      e_fa = 2'd0; e_fb = 2'd0;
`ifdef PIPE_HAZARD_FWD_EN
      if (bus.IDValid && !e_stall && !bus.BrTaken) begin
        if (da < 99) e_fa = 2'(da);
        if (db < 99) e_fb = 2'(db);
      end
`endif
      chk("stall", {15'd0, bus.Stall}, {15'd0, e_stall});
      chk("bubble", {15'd0, bus.Bubble}, {15'd0, e_stall});
      chk("flush", {15'd0, bus.Flush}, {15'd0, bus.BrTaken});
      chk("fwd_a", {14'd0, bus.FwdSelA}, {14'd0, e_fa});
      chk("fwd_b", {14'd0, bus.FwdSelB}, {14'd0, e_fb});
      chk("cnt", bus.StallCnt, m_cnt);
      if (bus.BrTaken)
        foreach (prods[i]) if (cyc - prods[i].t == 1) prods[i].live = 0;
      if (bus.IDValid && !e_stall && !bus.BrTaken && wr)
        prods.push_back('{t: cyc, dest: dst, ld: ld, live: 1});
      while (prods.size() > 0 && cyc - prods[0].t >= 3) void'(prods.pop_front());
      if (e_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    cyc++;
  end

  task automatic drive(input logic [7:0] ins, input logic v, input logic br, input logic r);
    @(posedge clk);
    #1;
    bus.IDInstr = ins;
    bus.IDValid = v;
    bus.BrTaken = br;
    rst = r;
    #2;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; forcing = 0; m_cnt = 16'd0;
    rst = 1'b1;
    bus.IDInstr = ADD12; bus.IDValid = 1'b1; bus.BrTaken = 1'b0;

    drive(ADD12, 1, 0, 1);
    drive(ADD12, 1, 0, 1);
    chk("pin_rst_stall", {15'd0, bus.Stall}, 16'd0);
    chk("pin_rst_bubble", {15'd0, bus.Bubble}, 16'd0);
    chk("pin_rst_flush", {15'd0, bus.Flush}, 16'd0);
    chk("pin_rst_cnt", bus.StallCnt, 16'd0);

    drive(ADD12, 1, 0, 0);
    chk("pin_add_nostall", {15'd0, bus.Stall}, 16'd0);
    drive(SUB31, 1, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    chk("pin_fwd_nostall", {15'd0, bus.Stall}, 16'd0);
    chk("pin_fwd_b1", {14'd0, bus.FwdSelB}, 16'd1);
`else
    chk("pin_raw_stall1", {15'd0, bus.Stall}, 16'd1);
    chk("pin_raw_bubble1", {15'd0, bus.Bubble}, 16'd1);
    chk("pin_raw_fwdb", {14'd0, bus.FwdSelB}, 16'd0);
`endif
    drive(SUB31, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_raw_stall2", {15'd0, bus.Stall}, 16'd1);
`endif
    drive(SUB31, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_raw_issue", {15'd0, bus.Stall}, 16'd0);
    chk("pin_raw_cnt", bus.StallCnt, 16'd2);
`endif
    drive(NOP, 1, 0, 0);
    drive(ADD20, 1, 0, 0);
    drive(ADD32, 1, 1, 0);
    chk("pin_br_flush", {15'd0, bus.Flush}, 16'd1);
    chk("pin_br_stall", {15'd0, bus.Stall}, 16'd0);
    drive(ADD03, 1, 0, 0);
    chk("pin_br_entry0_gone", {15'd0, bus.Stall}, 16'd0);
    chk("pin_br_flush_off", {15'd0, bus.Flush}, 16'd0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_br_cnt", bus.StallCnt, 16'd2);
`endif
    drive(NAND11, 1, 0, 0);
    drive(ADD22, 1, 0, 0);
    drive(ADD30, 1, 0, 0);
    chk("pin_wb_nostall", {15'd0, bus.Stall}, 16'd0);
    chk("pin_wb_fwd", {12'd0, bus.FwdSelA, bus.FwdSelB}, 16'd0);
    drive(LOAD20, 1, 0, 0);
`ifdef PIPE_HAZARD_FWD_EN
    chk("pin_fwd_a2", {14'd0, bus.FwdSelA}, 16'd2);
`else
    chk("pin_ex_stall", {15'd0, bus.Stall}, 16'd1);
`endif
    drive(LOAD20, 1, 0, 0);
    drive(ADD32, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_ld_stall", {15'd0, bus.Stall}, 16'd1);
`endif
    drive(ADD32, 1, 0, 0);
    drive(ADD32, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_ld_cnt", bus.StallCnt, 16'd5);
`endif
    drive(SHF13, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_shift_noryuse", {15'd0, bus.Stall}, 16'd0);
`endif
    drive(ORI, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_ori_r1", {15'd0, bus.Stall}, 16'd1);
`endif
    drive(ORI, 1, 0, 0);
    drive(ORI, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_ori_cnt", bus.StallCnt, 16'd7);
`endif
    drive(ST00, 1, 0, 0);
    drive(BZ11, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_bz_nosrc", {15'd0, bus.Stall}, 16'd0);
`endif
    drive(ADD11, 1, 0, 0);
    drive(ADD21, 0, 0, 0);
    chk("pin_novalid", {15'd0, bus.Stall}, 16'd0);
    drive(NOP, 1, 0, 0);
    drive(ADD10, 1, 0, 0);
    drive(ADD21, 1, 0, 0);
`ifndef PIPE_HAZARD_FWD_EN
    chk("pin_pre_rst_stall", {15'd0, bus.Stall}, 16'd1);
`endif
    drive(ADD21, 1, 0, 1);
    chk("pin_midrst_stall", {15'd0, bus.Stall}, 16'd0);
    chk("pin_midrst_bubble", {15'd0, bus.Bubble}, 16'd0);
    drive(ADD21, 1, 0, 0);
    chk("pin_postrst_stall", {15'd0, bus.Stall}, 16'd0);
    chk("pin_postrst_cnt", bus.StallCnt, 16'd0);

    drive(NOP, 0, 0, 0);
    force dut.stall = 1'b1;
    forcing = 1;
    repeat (65600) @(posedge clk);
    #1;
    release dut.stall;
    forcing = 0;
    #2;
    exp_q.push_back(16'hFFFF);
    chk("pin_sat", bus.StallCnt, exp_q.pop_front());
    drive(ADD10, 1, 0, 0);
    drive(ADD21, 1, 0, 0);
    chk("pin_sat_stall", {15'd0, bus.Stall}, 16'd1);
    drive(NOP, 1, 0, 0);
    chk("pin_sat_hold", bus.StallCnt, 16'hFFFF);
    drive(NOP, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
